uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART receiver. It sits directly downstream of the UART transmitter and consumes its serial line.
- Frame format: 8N1 (1 start bit, 8 data bits LSB first, 1 stop bit).
- Timing: oversampled by the system clock at CLKS_PER_BIT clocks per bit.
- Output: each good byte is delivered with a one-cycle valid strobe to the consuming logic.

Parameters:
CLKS_PER_BIT, 5208, system clocks per bit (50 MHz / 9600 baud); legal range 4..65535.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
serial  input  1  asynchronous RX line; idles high.
oByte  output  8  last correctly received byte.
oValid  output  1  one-cycle pulse when oByte has been updated.
oFrameErr  output  1  one-cycle pulse when the stop bit is sampled low.
oParityErr  output  1  one-cycle pulse on parity mismatch (see Optional Feature).
oActive  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Synchronizer: serial passes through 2 flops, both reset to 1. All decisions use the synced line.
- Clock counter: width is $clog2(CLKS_PER_BIT)+1 bits. Bit index is 3 bits. A shift/data register of 8 bits holds the byte under assembly.
- Reset values: oByte=0x00, oValid=0, oFrameErr=0, oParityErr=0, oActive=0, state=IDLE, counter=0, bit index=0.
- rst asserted at any time, including mid-frame, returns to IDLE on the next edge. No strobe is emitted for the partial frame.
- IDLE:
  - counter=0, bit index=0.
  - Synced line == 0 -> START; oActive<=1.
- START:
  - Count to (CLKS_PER_BIT-1)/2 (integer division) to reach mid-bit.
  - At mid-bit, synced line still 0 -> counter=0, go to DATA.
  - At mid-bit, synced line 1 -> glitch: go to IDLE, oActive<=0, no strobes.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample into bit[index] and reset the counter.
  - index<7 -> increment index. index==7 -> index=0, go to STOP (or PARITY if enabled).
- STOP:
  - Count to CLKS_PER_BIT-1, then sample.
  - Sample 1 -> oByte<=assembled byte, oValid<=1.
  - Sample 0 -> oFrameErr<=1; oByte unchanged.
  - In either case go to IDLE and set oActive<=0.
- Strobes: oValid, oFrameErr and oParityErr are high for exactly one clock; default low on every other cycle. They are mutually exclusive.
- Latency: oValid rises 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 clocks (±1) after the falling start edge reaches the serial pin.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A start edge immediately following a 1-bit stop must be detected.
- Line held low (break):
  - The frame completes with oFrameErr.
  - IDLE then sees 0 and re-enters START each frame time, producing repeated oFrameErr pulses. This is acceptable.
- The block never drops back-to-back frames. There is no backpressure; the consumer must take oByte on oValid.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP. After a full bit time it samples a 9th bit.
  - Even parity: the XOR of the 8 data bits and the parity bit must equal 0.
  - Mismatch: on reaching the stop sample, oParityErr<=1 and oValid is suppressed; oByte is unchanged.
  - If the stop bit is also bad, oFrameErr takes precedence and oParityErr stays 0.
- Not defined: no PARITY state; oParityErr is tied to 0.

Test Plan:
- CLKS_PER_BIT=16; drive frame 0xA5 at 16 clk/bit, stop=1 -> exactly one oValid pulse, oByte=0xA5, oFrameErr=0, oActive high during the frame and low after.
- serial low for 4 clocks, then high -> no strobes; oActive returns to 0 within 12 clocks; oByte unchanged.
- Receive 0x11 good, then frame 0x3C with stop bit 0 -> one oFrameErr pulse, no oValid, oByte stays 0x11.
- 0x00 immediately followed by 0xFF, each with exactly one stop bit -> two oValid pulses, oByte=0x00 then 0xFF, no errors.
- rst pulsed during data bit 3 of frame 0x77, then full frame 0x5A -> no strobe for 0x77; oValid with oByte=0x5A.
- UART_RX_PARITY_EN defined: 0x01 with parity bit 1 -> oValid, oByte=0x01. 0x03 with parity bit 1 -> oParityErr pulse, no oValid, oByte stays 0x01.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Signal bundle between the serial line, the uart_receiver and the logic consuming its bytes.
// The master side is the receiver; the slave side drives the line and takes the received bytes.
interface uart_receiver_if;
    logic       serial;
    logic [7:0] oByte;
    logic       oValid;
    logic       oFrameErr;
    logic       oParityErr;
    logic       oActive;

    modport master (
        input  serial,
        output oByte, oValid, oFrameErr, oParityErr, oActive
    );

    modport slave (
        output serial,
        input  oByte, oValid, oFrameErr, oParityErr, oActive
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, oversampled at CLKS_PER_BIT system clocks per bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic            clk,
    input  logic            rst,
    uart_receiver_if.master rx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    logic             serial_meta;
    logic             line;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       data_q;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             active_q;
`ifdef UART_RX_PARITY_EN
    logic             par_q;
    logic             parity_err_q;
`endif

    // Idle-high reset value keeps a reset release from looking like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            serial_meta <= 1'b1;
            line        <= 1'b1;
        end else begin
            // NOTE: non-blocking here is what makes these two separate flops; blocking would collapse the chain.
            serial_meta <= rx.serial;
            line        <= serial_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            data_q       <= '0;
            byte_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            active_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Strobes default low so each one lasts exactly one clock.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!line) begin
                        state    <= START;
                        active_q <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!line) begin
                            state <= DATA;
                        end else begin
                            state    <= IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt             <= '0;
                        data_q[bit_idx] <= line;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_CNT) begin
                        cnt   <= '0;
                        par_q <= line;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                // Leaving at mid-stop-bit leaves half a bit to catch an immediately following start edge.
                STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        active_q <= 1'b0;
                        if (!line) begin
                            frame_err_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (^{data_q, par_q}) begin
                            parity_err_q <= 1'b1;
`endif
                        end else begin
                            byte_q  <= data_q;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.oByte     = byte_q;
    assign rx.oValid    = valid_q;
    assign rx.oFrameErr = frame_err_q;
    assign rx.oActive   = active_q;
`ifdef UART_RX_PARITY_EN
    assign rx.oParityErr = parity_err_q;
`else
    assign rx.oParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit; a scoreboard queue holds the
// strobes each frame should produce and a negedge monitor retires them.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_receiver_if bus ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (bus.master)
    );

    always #5 clk = ~clk;

    typedef enum logic [1:0] {K_VALID, K_FRAME, K_PARITY} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Every strobe must match the oldest expectation, both in kind and in the byte presented.
    always @(negedge clk) begin
        int    n;
        kind_e k;
        exp_t  e;
        n = int'(bus.oValid) + int'(bus.oFrameErr) + int'(bus.oParityErr);
        if (n > 0) begin
            checks++;
            k = bus.oValid ? K_VALID : (bus.oFrameErr ? K_FRAME : K_PARITY);
            if (n > 1) begin
                errors++;
                $display("FAIL strobe_exclusive: %0d strobes high at once, required 1", n);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: kind=%s byte=%02h, required no strobe", k.name(), bus.oByte);
            end else begin
                e = exp_q.pop_front();
                if (k !== e.kind || bus.oByte !== e.data) begin
                    errors++;
                    $display("FAIL strobe: kind=%s byte=%02h, required kind=%s byte=%02h",
                             k.name(), bus.oByte, e.kind.name(), e.data);
                end
            end
        end
    end

    task automatic hold_bit(input logic v);
        bus.serial = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nb);
        for (int i = 0; i < nb; i++) hold_bit(bits[i]);
        bus.serial = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
`ifdef UART_RX_PARITY_EN
        send_bits({stop_bit, ^d, d, 1'b0}, 11);
`else
        send_bits({1'b0, stop_bit, d, 1'b0}, 10);
`endif
    endtask

    function automatic exp_t mk(input kind_e k, input logic [7:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        return e;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.oByte, bus.oValid, bus.oFrameErr, bus.oParityErr, bus.oActive} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: byte=%02h v=%b fe=%b pe=%b act=%b, required all zero",
                     bus.oByte, bus.oValid, bus.oFrameErr, bus.oParityErr, bus.oActive);
        end
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic test_basic;
        exp_q.push_back(mk(K_VALID, 8'hA5));
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (5 * CPB) @(negedge clk);
                checks++;
                if (bus.oActive !== 1'b1) begin
                    errors++;
                    $display("FAIL active_mid_frame: oActive=%b, required 1", bus.oActive);
                end
            end
        join
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (bus.oActive !== 1'b0) begin
            errors++;
            $display("FAIL active_after_frame: oActive=%b, required 0", bus.oActive);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_missing: %0d strobes outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_glitch;
        bit cleared = 1'b0;
        bus.serial = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.oActive !== 1'b1) begin
            errors++;
            $display("FAIL glitch_active: oActive=%b, required 1", bus.oActive);
        end
        bus.serial = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!bus.oActive) begin
                cleared = 1'b1;
                break;
            end
        end
        checks++;
        if (!cleared) begin
            errors++;
            $display("FAIL glitch_timeout: oActive=%b after 12 clocks, required 0", bus.oActive);
        end
        repeat (2 * CPB) @(negedge clk);
        checks++;
        if (bus.oByte !== 8'hA5) begin
            errors++;
            $display("FAIL glitch_byte: oByte=%02h, required a5", bus.oByte);
        end
    endtask

    task automatic test_frame_err;
        exp_q.push_back(mk(K_VALID, 8'h11));
        exp_q.push_back(mk(K_FRAME, 8'h11));
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.oByte !== 8'h11 || bus.oActive !== 1'b0) begin
            errors++;
            $display("FAIL frame_err: pending=%0d byte=%02h act=%b, required pending=0 byte=11 act=0",
                     exp_q.size(), bus.oByte, bus.oActive);
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        exp_q.push_back(mk(K_VALID, 8'h00));
        exp_q.push_back(mk(K_VALID, 8'hFF));
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.oByte !== 8'hFF) begin
            errors++;
            $display("FAIL back_to_back: pending=%0d byte=%02h, required pending=0 byte=ff",
                     exp_q.size(), bus.oByte);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d = 8'h77;
        hold_bit(1'b0);
        for (int i = 0; i < 3; i++) hold_bit(d[i]);
        bus.serial = d[3];
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        bus.serial = 1'b1;
        checks++;
        if (bus.oActive !== 1'b0 || bus.oByte !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_frame: act=%b byte=%02h, required act=0 byte=00", bus.oActive, bus.oByte);
        end
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        exp_q.push_back(mk(K_VALID, 8'h5A));
        send_frame(8'h5A, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.oByte !== 8'h5A) begin
            errors++;
            $display("FAIL after_reset_frame: pending=%0d byte=%02h, required pending=0 byte=5a",
                     exp_q.size(), bus.oByte);
            exp_q.delete();
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        exp_q.push_back(mk(K_VALID, 8'h01));
        exp_q.push_back(mk(K_PARITY, 8'h01));
        send_bits({1'b1, 1'b1, 8'h01, 1'b0}, 11);
        send_bits({1'b1, 1'b1, 8'h03, 1'b0}, 11);
        repeat (3 * CPB) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bus.oByte !== 8'h01) begin
            errors++;
            $display("FAIL parity: pending=%0d byte=%02h, required pending=0 byte=01", exp_q.size(), bus.oByte);
            exp_q.delete();
        end
    endtask
`endif

    initial begin
        bus.serial = 1'b1;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
